// File: rtl/i2c_target_pkg.sv
// Shared I2C definitions: FSM state encoding, bus-level ACK/NACK values and the address-match helper.
// Kept in a package so a future I2C master can reuse the same encodings.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } state_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
      return (addr_byte[7:1] == dev_addr);
   endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Pin and local register-bus signals of the I2C target; slave = the target, master = surrounding fabric/pins.
interface i2c_target_if #(
   parameter int REG_ADDR_BITS = 8
);
   logic                     scl_in;
   logic                     sda_in;
   logic                     sda_out;
   logic [REG_ADDR_BITS-1:0] reg_addr;
   logic [7:0]               reg_wdata;
   logic                     reg_wr;
   logic                     reg_rd;
   logic [7:0]               reg_rdata;
   logic                     busy;

   modport slave (
      input  scl_in, sda_in, reg_rdata,
      output sda_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy
   );

   modport master (
      output scl_in, sda_in, reg_rdata,
      input  sda_out, reg_addr, reg_wdata, reg_wr, reg_rd, busy
   );
endinterface

// File: rtl/i2c_target_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample agreement filter for one I2C line.
// Level idles high; rise/fall pulse for one clk in the cycle the filtered level changes.
module i2c_target_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1_q, sync2_q, lvl_q, rise_q, fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         lvl_q   <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         // The new level must persist for FILTER_LEN consecutive samples before it is accepted.
         if (sync2_q == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            lvl_q  <= sync2_q;
            rise_q <= sync2_q;
            fall_q <= ~sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, auto-incrementing register pointer,
// single-cycle reg_wr/reg_rd strobes on the local register bus. No clock stretching.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR      = 7'h50,
   parameter int         REG_ADDR_BITS = 8,
   parameter int         FILTER_LEN    = 3
) (
   input  logic         clk,
   input  logic         reset,
   i2c_target_if.slave  bus
);
   localparam int RAB = REG_ADDR_BITS;

   logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;

   i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(clk), .reset(reset), .pin_i(bus.scl_in),
      .lvl_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
   );

   i2c_target_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(clk), .reset(reset), .pin_i(bus.sda_in),
      .lvl_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
   );

   state_e         state_q;
   logic [2:0]     bit_cnt_q;
   logic [6:0]     rx_q;
   logic [6:0]     tx_q;
   logic           rw_q, rd_pend_q, sda_out_q, reg_wr_q, reg_rd_q, busy_q;
   logic [RAB-1:0] reg_addr_q;
   logic [7:0]     reg_wdata_q;

   logic       start_det, stop_det, last_bit;
   logic [7:0] rx_byte;

   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;
   assign rx_byte   = {rx_q, sda_f};
   assign last_bit  = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 7'd0;
         tx_q        <= 7'd0;
         rw_q        <= 1'b0;
         rd_pend_q   <= 1'b0;
         sda_out_q   <= 1'b1;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         busy_q      <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'd0;
      end else begin
         reg_wr_q  <= 1'b0;
         reg_rd_q  <= 1'b0;
         rd_pend_q <= reg_rd_q;
         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= 3'd0;
            sda_out_q <= 1'b1;
            rd_pend_q <= 1'b0;
         end else if (stop_det) begin
            state_q   <= ST_IDLE;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
            rd_pend_q <= 1'b0;
         end else begin
            // Fabric returns read data the clk after reg_rd; put its MSB on the line straight away.
            if (rd_pend_q && state_q == ST_RDATA) begin
               tx_q      <= bus.reg_rdata[6:0];
               sda_out_q <= bus.reg_rdata[7];
            end
            case (state_q)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (scl_rise) begin
                     rx_q      <= rx_byte[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) begin
                        case (state_q)
                           ST_ADDR: begin
                              if (addr_match(rx_byte, DEV_ADDR)) begin
                                 busy_q  <= 1'b1;
                                 rw_q    <= rx_byte[0];
                                 state_q <= ST_ADDR_ACK;
                              end else begin
                                 busy_q  <= 1'b0;
                                 state_q <= ST_IGNORE;
                              end
                           end
                           ST_PTR: begin
                              reg_addr_q <= RAB'(rx_byte);
                              state_q    <= ST_PTR_ACK;
                           end
                           default: begin
                              reg_wdata_q <= rx_byte;
                              reg_wr_q    <= 1'b1;
                              state_q     <= ST_WDATA_ACK;
                           end
                        endcase
                     end
                  end
               end
               // bit_cnt_q doubles as ACK phase: 0 = waiting for the fall that opens the ACK slot.
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == 3'd0) begin
                        sda_out_q <= ACK;
                        bit_cnt_q <= 3'd1;
                     end else begin
                        bit_cnt_q <= 3'd0;
                        case (state_q)
                           ST_ADDR_ACK: begin
                              if (rw_q) begin
                                 reg_rd_q <= 1'b1;
                                 state_q  <= ST_RDATA;
                              end else begin
                                 sda_out_q <= 1'b1;
                                 state_q   <= ST_PTR;
                              end
                           end
                           ST_PTR_ACK: begin
                              sda_out_q <= 1'b1;
                              state_q   <= ST_WDATA;
                           end
                           default: begin
                              sda_out_q  <= 1'b1;
                              reg_addr_q <= reg_addr_q + RAB'(1);
                              state_q    <= ST_WDATA;
                           end
                        endcase
                     end
                  end
               end
               ST_RDATA: begin
                  if (scl_fall) begin
                     tx_q      <= {tx_q[5:0], 1'b0};
                     sda_out_q <= tx_q[6];
                  end
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (last_bit) state_q <= ST_RDATA_ACK;
                  end
               end
               ST_RDATA_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == 3'd0) begin
                        sda_out_q <= 1'b1;
                        bit_cnt_q <= 3'd1;
                     end else begin
                        bit_cnt_q  <= 3'd0;
                        reg_addr_q <= reg_addr_q + RAB'(1);
                        reg_rd_q   <= 1'b1;
                        state_q    <= ST_RDATA;
                     end
                  end
                  if (scl_rise && sda_f == NACK) begin
                     state_q <= ST_IGNORE;
                     busy_q  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.sda_out   = sda_out_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_wr    = reg_wr_q;
   assign bus.reg_rd    = reg_rd_q;
   assign bus.busy      = busy_q;
endmodule
